// File: rtl/crypto1_sched.sv
// crypto1_sched: hands the 256 Crypto-1 search subspaces out to NCORES
// search cores one job at a time and tracks completions. The search stops
// on the first key a core reports, or once all 256 jobs have come back
// without a hit.
//
// Ports
//   CLK, RESETn            clock, asynchronous active-low reset
//   START / ABORT          begin a search / cancel and go idle (ABORT wins)
//   BUSY, DONE, FOUND      status; KEY is meaningful when DONE & FOUND
//   KEY[47:0]              recovered key
//   JOBS_DONE[8:0]         subspaces finished without a key (0..256)
//   CORE_RESETn[N-1:0]     per-core reset, high while the core runs a job
//   CORE_EIDX / CORE_OIDX  per-core even/odd subspace index, 4 bits per core
//   CORE_DONE / CORE_VALID per-core completion and key-found flags
//   CORE_KEY[48N-1:0]      per-core key

// One core slot. It holds the core in reset for at least HOLD cycles
// between jobs and keeps the subspace index stable while the job runs.
module crypto1_slot #(
  parameter int HOLD = 2
) (
  input  logic       gclk,
  input  logic       grst_n,
  input  logic       kill_i,    // abort or key found: stop this core now
  input  logic       issue_i,   // start a job on this slot
  input  logic       retire_i,  // job finished without a key
  input  logic [7:0] job_i,
  output logic       run_o,
  output logic       free_o,
  output logic [3:0] eidx_o,
  output logic [3:0] oidx_o
);
  logic       run_q;
  logic [3:0] hold_q, eidx_q, oidx_q;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      run_q  <= 1'b0;
      hold_q <= '0;
      eidx_q <= '0;
      oidx_q <= '0;
    end else if (kill_i) begin
      run_q  <= 1'b0;
      hold_q <= '0;
    end else if (issue_i) begin
      run_q  <= 1'b1;
      eidx_q <= job_i[7:4];
      oidx_q <= job_i[3:0];
    end else if (retire_i) begin
      run_q  <= 1'b0;
      hold_q <= '0;
    end else if (!run_q && hold_q < 4'(HOLD)) begin
      // count reset cycles, saturating once the slot is usable again
      hold_q <= hold_q + 4'd1;
    end
  end

  assign run_o  = run_q;
  assign free_o = !run_q && (hold_q >= 4'(HOLD));
  assign eidx_o = eidx_q;
  assign oidx_o = oidx_q;
endmodule

module crypto1_sched #(
  parameter int NCORES = 4,
  parameter int HOLD   = 2
) (
  input  logic                   CLK,
  input  logic                   RESETn,
  input  logic                   START,
  input  logic                   ABORT,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   FOUND,
  output logic [47:0]            KEY,
  output logic [8:0]             JOBS_DONE,
  output logic [NCORES-1:0]      CORE_RESETn,
  output logic [4*NCORES-1:0]    CORE_EIDX,
  output logic [4*NCORES-1:0]    CORE_OIDX,
  input  logic [NCORES-1:0]      CORE_DONE,
  input  logic [NCORES-1:0]      CORE_VALID,
  input  logic [48*NCORES-1:0]   CORE_KEY
);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FINISH} state_e;

  state_e              state_q, state_d;
  logic [8:0]          j_q, j_d, jobs_q, jobs_d, ncmp;
  logic                found_q, found_d, done_q, done_d;
  logic [47:0]         key_q, key_d, vkey;
  logic [NCORES-1:0]   run, free, vld, cmp, pick, issue_vec, retire_vec;
  logic                busy, any_vld, issue_en, kill;

  // Flags from slots that are not running are stale and must be ignored.
  assign vld      = CORE_VALID & run;
  assign cmp      = CORE_DONE & ~CORE_VALID & run;
  assign any_vld  = |vld;
  assign busy     = (state_q == DISPATCH) || (state_q == DRAIN);
  assign kill     = ABORT || (busy && any_vld);
  assign issue_en = (state_q == DISPATCH) && !ABORT && !any_vld && (|free);
  assign issue_vec  = issue_en ? pick : '0;
  assign retire_vec = (busy && !ABORT) ? cmp : '0;

  // Lowest-index free slot, lowest-index valid key, completion count.
  always_comb begin
    pick = '0;
    vkey = '0;
    ncmp = '0;
    for (int i = NCORES - 1; i >= 0; i--) begin
      if (free[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
      if (vld[i]) vkey = CORE_KEY[48*i +: 48];
    end
    for (int i = 0; i < NCORES; i++) ncmp = ncmp + 9'(cmp[i]);
  end

  for (genvar g = 0; g < NCORES; g++) begin : g_slot
    crypto1_slot #(.HOLD(HOLD)) u_slot (
      .gclk     (CLK),
      .grst_n   (RESETn),
      .kill_i   (kill),
      .issue_i  (issue_vec[g]),
      .retire_i (retire_vec[g]),
      .job_i    (j_q[7:0]),
      .run_o    (run[g]),
      .free_o   (free[g]),
      .eidx_o   (CORE_EIDX[4*g +: 4]),
      .oidx_o   (CORE_OIDX[4*g +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    jobs_d  = jobs_q;
    found_d = found_q;
    done_d  = done_q;
    key_d   = key_q;
    if (ABORT) begin
      state_d = IDLE;
      found_d = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (START) begin
            state_d = DISPATCH;
            j_d     = '0;
            jobs_d  = '0;
            found_d = 1'b0;
            done_d  = 1'b0;
          end
        end
        DISPATCH, DRAIN: begin
          jobs_d = jobs_q + ncmp;
          if (any_vld) begin
            key_d   = vkey;
            found_d = 1'b1;
            done_d  = 1'b1;
            state_d = FINISH;
          end else if (state_q == DISPATCH) begin
            if (issue_en) begin
              j_d = j_q + 9'd1;
              if (j_q == 9'd255) state_d = DRAIN;
            end
          end else if (run == '0) begin
            done_d  = 1'b1;
            state_d = FINISH;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      j_q     <= '0;
      jobs_q  <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
      key_q   <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      jobs_q  <= jobs_d;
      found_q <= found_d;
      done_q  <= done_d;
      key_q   <= key_d;
    end
  end

  assign BUSY        = busy;
  assign DONE        = done_q;
  assign FOUND       = found_q;
  assign KEY         = key_q;
  assign JOBS_DONE   = jobs_q;
  assign CORE_RESETn = run;
endmodule

// File: tb/tb_crypto1_sched.sv
// Directed bench for crypto1_sched: a 4-core build driven by a simple
// core model (fixed per-core latency, optional key hit) and a 1-core build.
module tb_crypto1_sched;
  localparam int N = 4;
  localparam int HOLD = 2;
  localparam logic [47:0] HITKEY = 48'hA0A1A2A3A4A5;

  logic CLK = 1'b0, RESETn = 1'b0, START = 1'b0, ABORT = 1'b0, START1 = 1'b0;
  logic BUSY, DONE, FOUND;
  logic [47:0] KEY;
  logic [8:0] JOBS_DONE;
  logic [N-1:0] CORE_RESETn, CORE_DONE, CORE_VALID;
  logic [4*N-1:0] CORE_EIDX, CORE_OIDX;
  logic [48*N-1:0] CORE_KEY;

  logic b1, d1, f1;
  logic [47:0] k1;
  logic [8:0] jd1;
  logic [0:0] cr1, cd1, cv1;
  logic [3:0] ce1, co1;
  logic [47:0] ck1;

  int total = 0, bad = 0;
  int lat[N];
  logic vjob_en = 1'b0;
  logic [7:0] vjob = 8'h00;
  logic [N-1:0] vmask = '0;
  int cnt[N];
  int c1;
  int q_iss[$];
  int min_low, max_delta;

  crypto1_sched #(.NCORES(N), .HOLD(HOLD)) dut (
    .CLK(CLK), .RESETn(RESETn), .START(START), .ABORT(ABORT),
    .BUSY(BUSY), .DONE(DONE), .FOUND(FOUND), .KEY(KEY), .JOBS_DONE(JOBS_DONE),
    .CORE_RESETn(CORE_RESETn), .CORE_EIDX(CORE_EIDX), .CORE_OIDX(CORE_OIDX),
    .CORE_DONE(CORE_DONE), .CORE_VALID(CORE_VALID), .CORE_KEY(CORE_KEY));

  crypto1_sched #(.NCORES(1), .HOLD(HOLD)) dut1 (
    .CLK(CLK), .RESETn(RESETn), .START(START1), .ABORT(1'b0),
    .BUSY(b1), .DONE(d1), .FOUND(f1), .KEY(k1), .JOBS_DONE(jd1),
    .CORE_RESETn(cr1), .CORE_EIDX(ce1), .CORE_OIDX(co1),
    .CORE_DONE(cd1), .CORE_VALID(cv1), .CORE_KEY(ck1));

  always #5 CLK = ~CLK;

  // Core model: lat[i] cycles after leaving reset the core reports either
  // DONE or, for the chosen job / masked cores, VALID with a key.
  always @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (!CORE_RESETn[i]) begin
        cnt[i] <= 0;
        CORE_DONE[i] <= 1'b0;
        CORE_VALID[i] <= 1'b0;
      end else begin
        cnt[i] <= cnt[i] + 1;
        if (cnt[i] + 1 == lat[i]) begin
          if (vmask[i] || (vjob_en && {CORE_EIDX[4*i +: 4], CORE_OIDX[4*i +: 4]} == vjob)) begin
            CORE_VALID[i] <= 1'b1;
            CORE_KEY[48*i +: 48] <= vjob_en ? HITKEY : {40'hC0DE000000, 8'(i)};
          end else begin
            CORE_DONE[i] <= 1'b1;
          end
        end
      end
    end
  end

  always @(posedge CLK) begin
    if (!cr1[0]) begin
      c1 <= 0;
      cd1 <= 1'b0;
      cv1 <= 1'b0;
    end else begin
      c1 <= c1 + 1;
      if (c1 + 1 == 10) cd1 <= 1'b1;
    end
  end
  assign ck1 = '0;

  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
  endtask

  // Step negedge by negedge, logging issues, reset gaps and JOBS_DONE steps,
  // until DONE, until stop_iss jobs were issued, or until the budget runs out.
  task automatic observe(input int budget, input int stop_iss, output bit to);
    int lowc[N];
    logic [N-1:0] prev;
    logic [8:0] pjd;
    for (int i = 0; i < N; i++) lowc[i] = 99;
    prev = CORE_RESETn;
    pjd = JOBS_DONE;
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) begin
        if (CORE_RESETn[i] && !prev[i]) begin
          q_iss.push_back(int'({CORE_EIDX[4*i +: 4], CORE_OIDX[4*i +: 4]}));
          if (lowc[i] < min_low) min_low = lowc[i];
          lowc[i] = 0;
        end else if (!CORE_RESETn[i]) begin
          lowc[i]++;
        end
      end
      prev = CORE_RESETn;
      if (JOBS_DONE > pjd && int'(JOBS_DONE - pjd) > max_delta) max_delta = int'(JOBS_DONE - pjd);
      pjd = JOBS_DONE;
      if (DONE || (stop_iss > 0 && q_iss.size() >= stop_iss)) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    total++; if ({BUSY, DONE, FOUND} !== 3'b000) begin bad++; $display("FAIL rst_status: got %b want 000", {BUSY, DONE, FOUND}); end
    total++; if (KEY !== 48'h0 || JOBS_DONE !== 9'd0) begin bad++; $display("FAIL rst_key_jobs: got %h/%0d want 0/0", KEY, JOBS_DONE); end
    total++; if (CORE_RESETn !== '0 || CORE_EIDX !== '0 || CORE_OIDX !== '0) begin bad++; $display("FAIL rst_cores: got %b %h %h want 0", CORE_RESETn, CORE_EIDX, CORE_OIDX); end
    total++; if (cr1 !== 1'b0 || b1 !== 1'b0) begin bad++; $display("FAIL rst_dut1: got %b %b want 0 0", cr1, b1); end
    // release with START waiting: slots only become free HOLD edges later
    RESETn = 1'b1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    total++; if (BUSY !== 1'b1 || CORE_RESETn !== 4'b0000) begin bad++; $display("FAIL rel_edge1: got busy=%b cr=%b want 1 0000", BUSY, CORE_RESETn); end
    @(negedge CLK);
    total++; if (CORE_RESETn !== 4'b0000) begin bad++; $display("FAIL rel_edge2: got %b want 0000", CORE_RESETn); end
    @(negedge CLK);
    total++; if (CORE_RESETn !== 4'b0001 || CORE_EIDX[3:0] !== 4'h0 || CORE_OIDX[3:0] !== 4'h0) begin bad++; $display("FAIL rel_first_issue: got %b %h %h want 0001 0 0", CORE_RESETn, CORE_EIDX[3:0], CORE_OIDX[3:0]); end
    @(negedge CLK);
    total++; if (CORE_RESETn !== 4'b0011 || CORE_OIDX[7:4] !== 4'h1) begin bad++; $display("FAIL second_issue: got %b oidx=%h want 0011 1", CORE_RESETn, CORE_OIDX[7:4]); end
    ABORT = 1'b1; @(negedge CLK); ABORT = 1'b0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_full_run();
    bit to;
    int nbad = 0;
    q_iss.delete(); min_low = 99; max_delta = 0;
    pulse_start();
    total++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin bad++; $display("FAIL full_busy: got %b %b want 1 0", BUSY, DONE); end
    observe(6000, 0, to);
    total++; if (to) begin bad++; $display("FAIL full_timeout: got no DONE want DONE"); end
    total++; if (JOBS_DONE !== 9'd256) begin bad++; $display("FAIL full_jobs: got %0d want 256", JOBS_DONE); end
    total++; if ({BUSY, DONE, FOUND} !== 3'b010) begin bad++; $display("FAIL full_status: got %b want 010", {BUSY, DONE, FOUND}); end
    total++; if (CORE_RESETn !== '0) begin bad++; $display("FAIL full_cores: got %b want 0", CORE_RESETn); end
    total++; if (q_iss.size() != 256) begin bad++; $display("FAIL full_issue_cnt: got %0d want 256", q_iss.size()); end
    foreach (q_iss[k]) if (q_iss[k] != k) nbad++;
    total++; if (nbad != 0) begin bad++; $display("FAIL full_order: got %0d out-of-order want 0", nbad); end
    total++; if (min_low < HOLD) begin bad++; $display("FAIL full_hold_gap: got %0d want >=%0d", min_low, HOLD); end
    repeat (3) @(negedge CLK);
    total++; if (JOBS_DONE !== 9'd256 || DONE !== 1'b1) begin bad++; $display("FAIL full_hold_result: got %0d %b want 256 1", JOBS_DONE, DONE); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_found();
    bit to;
    int mx = 0;
    logic [8:0] jd;
    q_iss.delete(); vjob_en = 1'b1; vjob = 8'h5C;
    pulse_start();
    observe(3000, 0, to);
    total++; if (to) begin bad++; $display("FAIL found_timeout: got no DONE want DONE"); end
    total++; if (KEY !== HITKEY) begin bad++; $display("FAIL found_key: got %h want %h", KEY, HITKEY); end
    total++; if ({BUSY, DONE, FOUND} !== 3'b011) begin bad++; $display("FAIL found_status: got %b want 011", {BUSY, DONE, FOUND}); end
    total++; if (CORE_RESETn !== '0) begin bad++; $display("FAIL found_cores: got %b want 0", CORE_RESETn); end
    foreach (q_iss[k]) if (q_iss[k] > mx) mx = q_iss[k];
    total++; if (mx > 'h5C + N) begin bad++; $display("FAIL found_overrun: got max job %h want <=%h", mx, 'h5C + N); end
    jd = JOBS_DONE;
    vjob_en = 1'b0;
    repeat (4) @(negedge CLK);
    total++; if (KEY !== HITKEY || FOUND !== 1'b1 || JOBS_DONE !== jd) begin bad++; $display("FAIL found_stable: got %h %b %0d want %h 1 %0d", KEY, FOUND, JOBS_DONE, HITKEY, jd); end
  endtask

  task automatic test_dual_valid();
    bit to;
    // staggered latencies line up the first batch's results on one cycle
    lat[0] = 13; lat[1] = 12; lat[2] = 11; lat[3] = 10; vmask = 4'b1010;
    pulse_start();
    observe(300, 0, to);
    total++; if (to || FOUND !== 1'b1) begin bad++; $display("FAIL dual_found: got to=%b found=%b want 0 1", to, FOUND); end
    total++; if (KEY !== {40'hC0DE000000, 8'd1}) begin bad++; $display("FAIL dual_key: got %h want c0de00000001", KEY); end
    vmask = '0;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_simul_done();
    bit to;
    max_delta = 0;
    pulse_start();
    observe(6000, 0, to);
    total++; if (to || JOBS_DONE !== 9'd256 || FOUND !== 1'b0) begin bad++; $display("FAIL simul_run: got to=%b jobs=%0d found=%b want 0 256 0", to, JOBS_DONE, FOUND); end
    total++; if (max_delta != 4) begin bad++; $display("FAIL simul_step: got %0d want 4", max_delta); end
    for (int i = 0; i < N; i++) lat[i] = 10;
    repeat (5) @(negedge CLK);
  endtask

  task automatic test_abort();
    bit to;
    logic [8:0] jd;
    q_iss.delete();
    pulse_start();
    observe(2000, 40, to);
    total++; if (to || q_iss.size() != 40) begin bad++; $display("FAIL abort_reach40: got to=%b n=%0d want 0 40", to, q_iss.size()); end
    jd = JOBS_DONE;
    ABORT = 1'b1; START = 1'b1;
    @(negedge CLK); ABORT = 1'b0; START = 1'b0;
    total++; if ({BUSY, DONE, FOUND} !== 3'b000 || CORE_RESETn !== '0) begin bad++; $display("FAIL abort_idle: got %b cr=%b want 000 0", {BUSY, DONE, FOUND}, CORE_RESETn); end
    total++; if (JOBS_DONE !== jd) begin bad++; $display("FAIL abort_jobs_kept: got %0d want %0d", JOBS_DONE, jd); end
    q_iss.delete();
    pulse_start();
    total++; if (JOBS_DONE !== 9'd0 || BUSY !== 1'b1) begin bad++; $display("FAIL restart_clear: got %0d %b want 0 1", JOBS_DONE, BUSY); end
    observe(6000, 0, to);
    total++; if (to || q_iss.size() == 0 || q_iss[0] != 0) begin bad++; $display("FAIL restart_first: got to=%b n=%0d want first job 0", to, q_iss.size()); end
    total++; if (JOBS_DONE !== 9'd256) begin bad++; $display("FAIL restart_jobs: got %0d want 256", JOBS_DONE); end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_async_reset();
    bit to;
    q_iss.delete();
    pulse_start();
    observe(2000, 20, to);
    #2 RESETn = 1'b0;
    #1;
    total++; if ({BUSY, DONE, FOUND} !== 3'b000 || CORE_RESETn !== '0) begin bad++; $display("FAIL async_status: got %b cr=%b want 000 0", {BUSY, DONE, FOUND}, CORE_RESETn); end
    total++; if (KEY !== 48'h0 || JOBS_DONE !== 9'd0 || CORE_EIDX !== '0 || CORE_OIDX !== '0) begin bad++; $display("FAIL async_regs: got %h %0d %h %h want 0", KEY, JOBS_DONE, CORE_EIDX, CORE_OIDX); end
    @(negedge CLK);
    #2 RESETn = 1'b1; START = 1'b1;
    @(negedge CLK); START = 1'b0;
    total++; if (CORE_RESETn !== '0) begin bad++; $display("FAIL async_hold1: got %b want 0", CORE_RESETn); end
    @(negedge CLK);
    total++; if (CORE_RESETn !== '0) begin bad++; $display("FAIL async_hold2: got %b want 0", CORE_RESETn); end
    q_iss.delete();
    observe(6000, 0, to);
    total++; if (to || JOBS_DONE !== 9'd256 || q_iss.size() == 0 || q_iss[0] != 0) begin bad++; $display("FAIL async_rerun: got to=%b jobs=%0d want 0 256 from job 0", to, JOBS_DONE); end
  endtask

  task automatic test_single_core();
    int q1[$];
    int nbad = 0;
    logic prev;
    bit to = 1'b1;
    @(negedge CLK); START1 = 1'b1;
    @(negedge CLK); START1 = 1'b0;
    prev = cr1[0];
    for (int c = 0; c < 8000; c++) begin
      @(negedge CLK);
      if (cr1[0] && !prev) q1.push_back(int'({ce1, co1}));
      prev = cr1[0];
      if (d1) begin to = 1'b0; break; end
    end
    total++; if (to || jd1 !== 9'd256) begin bad++; $display("FAIL single_jobs: got to=%b jobs=%0d want 0 256", to, jd1); end
    foreach (q1[k]) if (q1[k] != k) nbad++;
    total++; if (q1.size() != 256 || nbad != 0) begin bad++; $display("FAIL single_order: got n=%0d bad=%0d want 256 0", q1.size(), nbad); end
    total++; if ({b1, f1} !== 2'b00) begin bad++; $display("FAIL single_status: got %b want 00", {b1, f1}); end
  endtask

  initial begin
    for (int i = 0; i < N; i++) lat[i] = 10;
    test_reset();
    test_full_run();
    test_found();
    test_dual_valid();
    test_simul_done();
    test_abort();
    test_async_reset();
    test_single_core();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
